// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer driving one external 1-bit full adder, LSB first.
//   Optional feature macro SERIAL_ADDER_SUB_EN adds input sub (a_in - b_in, carry_out=1 means no borrow).
//   Ports: clk/n_rst (async active-low); start, a_in, b_in, cin request side;
//   add_a/add_b/add_cin to and add_sum/add_cout from the full adder;
//   busy, done (1-cycle pulse), sum_out/carry_out (held result).
module serial_adder_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a_in,
  input  logic [NUM_BITS-1:0] b_in,
  input  logic                cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic                sub,
`endif
  output logic                add_a,
  output logic                add_b,
  output logic                add_cin,
  input  logic                add_sum,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum_out,
  output logic                carry_out
);
  localparam int CW = $clog2(NUM_BITS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next_state;
  logic [NUM_BITS-1:0] a_sr, b_sr, sum_sr, b_ld;
  logic [CW-1:0] cnt;
  logic carry_q, c_ld, load, last;
`ifdef SERIAL_ADDER_SUB_EN
  // subtraction as a + ~b + 1
  assign b_ld = sub ? ~b_in : b_in;
  assign c_ld = sub | cin;
`else
  assign b_ld = b_in;
  assign c_ld = cin;
`endif
  assign load = start && state != RUN;
  assign last = state == RUN && cnt == CW'(NUM_BITS - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // full adder inputs come only from registers, gated to zero outside RUN
  assign add_a = busy & a_sr[0];
  assign add_b = busy & b_sr[0];
  assign add_cin = busy & carry_q;
  always_comb begin
    next_state = state;
    next_state = load ? RUN : busy ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr <= '0;
      b_sr <= '0;
      sum_sr <= '0;
      carry_q <= 1'b0;
      cnt <= '0;
      sum_out <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      a_sr <= a_in;
      b_sr <= b_ld;
      carry_q <= c_ld;
      cnt <= '0;
    end else if (busy) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      sum_sr <= {add_sum, sum_sr[NUM_BITS-1:1]};
      carry_q <= add_cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum_out <= {add_sum, sum_sr[NUM_BITS-1:1]};
        carry_out <= add_cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;
  localparam int N = 8;
  logic clk = 0, n_rst = 0, start = 0, cin = 0, sub = 0;
  logic [N-1:0] a_in = '0, b_in = '0, sum_out;
  logic add_a, add_b, add_cin, add_sum, add_cout, busy, done, carry_out;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a ^ add_b ^ add_cin;
  assign add_cout = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);

  serial_adder_ctrl #(.NUM_BITS(N)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
    logic [N-1:0] nb;
    nb = ~b;
    return s ? ({1'b0, a} + {1'b0, nb} + (N+1)'(1)) : ({1'b0, a} + {1'b0, b} + (N+1)'(c));
  endfunction

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= N + 3; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; sub = s; start = 1;
    @(posedge clk); #1;
    start = 0; a_in = N'($urandom); b_in = N'($urandom); cin = 1'($urandom);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
    int lat, bcnt;
    logic [N:0] e;
    e = model(a, b, c, s);
    issue(a, b, c, s);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_busy"}, bcnt, N);
    chk({tag, "_sum"}, sum_out, e[N-1:0]);
    chk({tag, "_cout"}, carry_out, e[N]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, dcnt;
    logic [N:0] e;
    logic [N-1:0] held, got_sum;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk) n_rst = 1;
    @(negedge clk);
    chk("idle_add", {add_a, add_b, add_cin}, 0);
    do_op("t1", 8'h3C, 8'h25, 0, 0);
    chk("t1_sum_const", sum_out, 8'h61);
    do_op("t2a", 8'hFF, 8'h01, 0, 0);
    chk("t2a_const", {carry_out, sum_out}, 9'h100);
    do_op("t2b", 8'hFF, 8'hFF, 1, 0);
    chk("t2b_const", {carry_out, sum_out}, 9'h1FF);
    // start re-pulsed mid-run must be ignored
    e = model(8'h12, 8'h34, 1, 0);
    issue(8'h12, 8'h34, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; cin = 1; start = 1;
    @(posedge clk); #1 start = 0;
    dcnt = 0; got_sum = '0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (done) begin dcnt++; got_sum = sum_out; end
    end
    chk("t3_dones", dcnt, 1);
    chk("t3_sum", got_sum, e[N-1:0]);
    chk("t3_idle", busy, 0);
    // back-to-back: start held in DONE
    do_op("t4a", 8'h40, 8'h41, 0, 0);
    held = sum_out;
    a_in = 8'h01; b_in = 8'h02; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1 start = 0;
    chk("t4_run", busy, 1);
    chk("t4_hold", sum_out, held);
    wait_done(lat, bcnt);
    chk("t4_lat", lat, N);
    chk("t4_sum", {carry_out, sum_out}, 9'h003);
    // asynchronous reset mid-run
    issue(8'hF0, 8'h0F, 1, 0);
    repeat (3) @(posedge clk);
    #2 n_rst = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_sum", sum_out, 0);
    chk("t5_cout", carry_out, 0);
    chk("t5_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk) n_rst = 1;
    do_op("t5_after", 8'h77, 8'h88, 1, 0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op("t6a", 8'h10, 8'h01, 0, 1);
    chk("t6a_const", {carry_out, sum_out}, 9'h10F);
    do_op("t6b", 8'h01, 8'h02, 1, 1);
    chk("t6b_const", {carry_out, sum_out}, 9'h0FF);
`endif
    for (int k = 0; k < 20; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      do_op("rnd", N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
`else
      do_op("rnd", N'($urandom), N'($urandom), 1'($urandom), 1'b0);
`endif
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
